store_buffer: RTL and testbench

Write-buffered memory-stage front end placed between the EX/MEM pipeline register and the data memory `dm`. Stores are queued in a small FIFO and written to `dm` lazily: in idle cycles, or when forced by a full buffer, a conflicting load, or a flush. Loads use the single `dm` address port directly. A load that overlaps a buffered store stalls the pipeline until the overlapping entries have drained. Optionally, a load is forwarded straight from an exact-match word store instead of stalling.

---
 rtl/store_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_store_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer between EX/MEM and the data memory; lazy FIFO write-back.
// Optional load forwarding from exact word stores: define STBUF_FWD_EN.
module store_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [6:0]  req_addr,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        sb_empty,
  output logic        dm_we,
  output logic [6:0]  dm_addr,
  output logic [2:0]  dm_type,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;

  logic [6:0]    addr_q [DEPTH];
  logic [2:0]    type_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head;
  logic [CW-1:0] count;
  logic [PW-1:0] tail;
  logic [PW-1:0] idx;
  logic [PW-1:0] yidx;
  logic          hit;
  logic          enq;
  logic          drain;
  logic          ld_acc;

  function automatic logic [2:0] fp_size(input logic [2:0] t);
    if (t == DM_WORD) return 3'd4;
    if (t == DM_HALF || t == DM_HALF_U) return 3'd2;
    return 3'd1;
  endfunction

  function automatic logic spans(input logic [6:0] a,
                                 input logic [2:0] t);
    logic [2:0] e;
    e = {1'b0, a[1:0]} + fp_size(t);
    return e > 3'd4;
  endfunction

  function automatic logic overlap(input logic [6:0] a,
                                   input logic [2:0] ta,
                                   input logic [6:0] b,
                                   input logic [2:0] tb);
    logic [4:0] wa, wb, na, nb;
    wa = a[6:2];
    wb = b[6:2];
    na = wa + 5'd1;
    nb = wb + 5'd1;
    return (wa == wb) || (spans(a, ta) && na == wb) ||
           (spans(b, tb) && nb == wa);
  endfunction

  assign tail     = head + count[PW-1:0];
  assign sb_empty = (count == '0);

  // Find the youngest live entry whose footprint overlaps the request
  always_comb begin
    hit  = 1'b0;
    yidx = head;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + i[PW-1:0];
      if (CW'(i) < count &&
          overlap(req_addr, req_type, addr_q[idx], type_q[idx])) begin
        hit  = 1'b1;
        yidx = idx;
      end
    end
  end

`ifdef STBUF_FWD_EN
  logic        fwd_ok;
  logic        ld_fwd;
  logic [31:0] fwd_data;
  logic [31:0] fwd_raw;

  // Extend the forwarded word store data as the load type asks
  always_comb begin
    fwd_ok   = hit && type_q[yidx] == DM_WORD &&
               addr_q[yidx] == req_addr;
    fwd_raw  = data_q[yidx];
    fwd_data = fwd_raw;
    unique case (req_type)
      DM_HALF:   fwd_data = {{16{fwd_raw[15]}}, fwd_raw[15:0]};
      DM_HALF_U: fwd_data = {16'h0, fwd_raw[15:0]};
      DM_BYTE:   fwd_data = {{24{fwd_raw[7]}}, fwd_raw[7:0]};
      3'b100:    fwd_data = {24'h0, fwd_raw[7:0]};
      default:   fwd_data = fwd_raw;
    endcase
  end
`endif

  // Arbitrate the dm port: store enqueue, load, or head drain
  always_comb begin
    stall   = 1'b0;
    enq     = 1'b0;
    drain   = 1'b0;
    ld_acc  = 1'b0;
`ifdef STBUF_FWD_EN
    ld_fwd  = 1'b0;
`endif
    dm_we   = 1'b0;
    dm_addr = '0;
    dm_type = '0;
    dm_din  = '0;
    if (!rst) begin
      if (req_valid && req_we) begin
        if (count < CW'(DEPTH)) begin
          enq = 1'b1;
        end else begin
          stall = 1'b1;
          drain = 1'b1;
        end
      end else if (req_valid) begin
        if (flush && count != '0) begin
          stall = 1'b1;
          drain = 1'b1;
        end else if (hit) begin
`ifdef STBUF_FWD_EN
          if (fwd_ok) begin
            ld_acc = 1'b1;
            ld_fwd = 1'b1;
          end else begin
            stall = 1'b1;
            drain = 1'b1;
          end
`else
          stall = 1'b1;
          drain = 1'b1;
`endif
        end else begin
          ld_acc = 1'b1;
        end
      end else if (count != '0) begin
        drain = 1'b1;
      end
      if (drain) begin
        dm_we   = 1'b1;
        dm_addr = addr_q[head];
        dm_type = type_q[head];
        dm_din  = data_q[head];
`ifdef STBUF_FWD_EN
      end else if (ld_acc && !ld_fwd) begin
`else
      end else if (ld_acc) begin
`endif
        dm_addr = req_addr;
        dm_type = req_type;
      end
    end
  end

  // FIFO pointers, entry storage and the registered load result
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      count      <= '0;
      load_valid <= 1'b0;
      load_data  <= '0;
    end else begin
      if (enq) begin
        addr_q[tail] <= req_addr;
        type_q[tail] <= req_type;
        data_q[tail] <= req_wdata;
      end
      if (drain) head <= head + 1'b1;
      unique case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      load_valid <= ld_acc;
      if (ld_acc) begin
`ifdef STBUF_FWD_EN
        load_data <= ld_fwd ? fwd_data : dm_dout;
`else
        load_data <= dm_dout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed stores/loads against a byte memory,
// load results checked by a scoreboard monitor.
module tb_store_buffer;

  localparam int DEPTH = 2;
  localparam logic [2:0] W  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] B  = 3'b011;
  localparam logic [2:0] BU = 3'b100;
`ifdef STBUF_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [6:0]  req_addr;
  logic [2:0]  req_type;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        sb_empty;
  logic        dm_we;
  logic [6:0]  dm_addr;
  logic [2:0]  dm_type;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mem [128];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
    .flush(flush), .stall(stall), .load_valid(load_valid),
    .load_data(load_data), .sb_empty(sb_empty), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_type(dm_type), .dm_din(dm_din),
    .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  // Byte-addressed little-endian data memory
  always @(posedge clk) begin
    if (dm_we) begin
      mem[dm_addr] <= dm_din[7:0];
      if (dm_type == W || dm_type == H || dm_type == 3'b010)
        mem[dm_addr + 7'd1] <= dm_din[15:8];
      if (dm_type == W) begin
        mem[dm_addr + 7'd2] <= dm_din[23:16];
        mem[dm_addr + 7'd3] <= dm_din[31:24];
      end
    end
  end

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[dm_addr];
    b1 = mem[dm_addr + 7'd1];
    b2 = mem[dm_addr + 7'd2];
    b3 = mem[dm_addr + 7'd3];
    dm_dout = '0;
    case (dm_type)
      W:       dm_dout = {b3, b2, b1, b0};
      H:       dm_dout = {{16{b1[7]}}, b1, b0};
      3'b010:  dm_dout = {16'h0, b1, b0};
      B:       dm_dout = {{24{b0[7]}}, b0};
      BU:      dm_dout = {24'h0, b0};
      default: dm_dout = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every load_valid pops one expected result
  always @(negedge clk) begin
    if (!rst && load_valid) begin
      if (exp_q.size() == 0) chk("unexpected_load_valid", 32'd1, 32'd0);
      else chk("load_data", load_data, exp_q.pop_front());
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [6:0] a, input logic [2:0] t,
                       input logic [31:0] d, output int n);
    n = 0;
    req_valid = 1'b1; req_we = 1'b1;
    req_addr = a; req_type = t; req_wdata = d;
    @(negedge clk);
    while (stall && n < 8) begin
      next();
      @(negedge clk);
      n++;
    end
    if (n >= 8) chk("store_timeout", 32'd1, 32'd0);
    next();
    req_valid = 1'b0;
  endtask

  task automatic load(input logic [6:0] a, input logic [2:0] t,
                      input logic [31:0] e, output int n);
    n = 0;
    req_valid = 1'b1; req_we = 1'b0;
    req_addr = a; req_type = t; req_wdata = '0;
    @(negedge clk);
    while (stall && n < 8) begin
      next();
      @(negedge clk);
      n++;
    end
    if (n >= 8) chk("load_timeout", 32'd1, 32'd0);
    else exp_q.push_back(e);
    next();
    req_valid = 1'b0;
  endtask

  task automatic drain_all();
    int n = 0;
    req_valid = 1'b0;
    @(negedge clk);
    while (!sb_empty && n < 20) begin
      next();
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb_empty), 32'd1);
    next();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h40] = 8'h44; mem[7'h41] = 8'h33;
    mem[7'h42] = 8'h22; mem[7'h43] = 8'h11;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_type = '0; req_wdata = '0; flush = 1'b0;
    next();
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_dm_we", 32'(dm_we), 32'd0);
    chk("idle_sb_empty", 32'(sb_empty), 32'd1);
    chk("idle_load_valid", 32'(load_valid), 32'd0);
    chk("idle_load_data", load_data, 32'h0);
    next();

    store(7'h10, W, 32'hDEADBEEF, n);
    chk("st10_stall", 32'(n), 32'd0);
    @(negedge clk);
    chk("drain_we", 32'(dm_we), 32'd1);
    chk("drain_addr", 32'(dm_addr), 32'h10);
    chk("drain_type", 32'(dm_type), 32'(W));
    chk("drain_din", dm_din, 32'hDEADBEEF);
    chk("drain_not_empty", 32'(sb_empty), 32'd0);
    next();
    @(negedge clk);
    chk("after_drain_empty", 32'(sb_empty), 32'd1);
    next();
    load(7'h10, W, 32'hDEADBEEF, n);
    chk("ld10_stall", 32'(n), 32'd0);

    req_valid = 1'b1; req_we = 1'b1; req_type = W;
    req_addr = 7'h00; req_wdata = 32'h01010101;
    @(negedge clk);
    chk("full_st0_stall", 32'(stall), 32'd0);
    next();
    req_addr = 7'h04; req_wdata = 32'h02020202;
    @(negedge clk);
    chk("full_st1_stall", 32'(stall), 32'd0);
    next();
    req_addr = 7'h08; req_wdata = 32'h03030303;
    @(negedge clk);
    chk("full_stall", 32'(stall), 32'd1);
    chk("full_dm_we", 32'(dm_we), 32'd1);
    chk("full_dm_addr", 32'(dm_addr), 32'h00);
    chk("full_dm_din", dm_din, 32'h01010101);
    next();
    @(negedge clk);
    chk("full_retry_stall", 32'(stall), 32'd0);
    chk("full_retry_dm_we", 32'(dm_we), 32'd0);
    next();
    req_valid = 1'b0;
    drain_all();
    load(7'h08, W, 32'h03030303, n);
    chk("ld08_stall", 32'(n), 32'd0);

    store(7'h21, B, 32'h000000AB, n);
    load(7'h21, BU, 32'h000000AB, n);
    chk("byte_conflict_stall", 32'(n), 32'd1);
    drain_all();

    store(7'h30, W, 32'h8000FF7F, n);
    load(7'h30, B, 32'h0000007F, n);
    chk("fwd_byte_stall", 32'(n), FWD ? 32'd0 : 32'd1);
    drain_all();
    store(7'h30, W, 32'h8000FF7F, n);
    load(7'h30, H, 32'hFFFFFF7F, n);
    chk("fwd_half_stall", 32'(n), FWD ? 32'd0 : 32'd1);
    drain_all();

    store(7'h00, W, 32'h0A0B0C0D, n);
    store(7'h04, W, 32'h11112222, n);
    load(7'h04, W, 32'h11112222, n);
    chk("fifo_order_stall", 32'(n), FWD ? 32'd0 : 32'd2);
    drain_all();

    store(7'h23, H, 32'h00005566, n);
    load(7'h24, W, 32'h00000055, n);
    chk("span_stall", 32'(n), 32'd1);
    drain_all();

    store(7'h50, W, 32'h12345678, n);
    flush = 1'b1;
    load(7'h60, W, 32'h00000000, n);
    flush = 1'b0;
    chk("flush_stall", 32'(n), 32'd1);
    drain_all();

    store(7'h40, W, 32'hAAAAAAAA, n);
    store(7'h44, W, 32'hBBBBBBBB, n);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_dm_we", 32'(dm_we), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_empty", 32'(sb_empty), 32'd1);
    chk("postrst_dm_we", 32'(dm_we), 32'd0);
    next();
    load(7'h40, W, 32'h11223344, n);
    chk("postrst_ld_stall", 32'(n), 32'd0);
    load(7'h44, W, 32'h00000000, n);

    for (int i = 0; i < 4; i++) next();
    chk("pending_loads", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
